// File: rtl/round_pkg.sv
// Shared types and constants for the round controller: state encoding,
// field widths, HOLD length and the saturating score increment.
package round_pkg;

  localparam int SCORE_W  = 7;
  localparam int SEC_W    = 6;
  localparam int HOLD_SEC = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_GAME  = 2'd2,
    ST_HOLD  = 2'd3
  } round_state_e;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v,
                                                 input logic [SCORE_W-1:0] max_v);
    return (v >= max_v) ? max_v : v + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/sec_tick.sv
// Game-second divider: tick is high for one cycle every TICK_DIV cycles,
// counted from the last rst/clr edge.
module sec_tick #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Not gated by clr: the FSM derives clr from tick, so gating would loop.
  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/round_ctrl.sv
// Round controller: IDLE -> COUNT -> GAME -> HOLD sequencing, per-player scores,
// frozen last-round scores. Define ROUND_CTRL_HISCORE_EN to track best_score.
module round_ctrl
  import round_pkg::*;
#(
  parameter int TICK_DIV      = 100000000,
  parameter int ROUND_SEC     = 30,
  parameter int COUNTDOWN_SEC = 3,
  parameter int NUM_PLAYERS   = 2,
  parameter int SCORE_MAX     = 99
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           abort,
  input  logic [NUM_PLAYERS-1:0]         hit,
  output logic [1:0]                     state,
  output logic [SEC_W-1:0]               sec_left,
  output logic [SCORE_W*NUM_PLAYERS-1:0] score,
  output logic [SCORE_W*NUM_PLAYERS-1:0] last_score,
  output logic                           jump_start,
  output logic                           round_done,
  output logic [SCORE_W-1:0]             best_score
);

  localparam logic [SEC_W-1:0]   ROUND_LD = SEC_W'(ROUND_SEC);
  localparam logic [SEC_W-1:0]   CD_LD    = SEC_W'(COUNTDOWN_SEC);
  localparam logic [SEC_W-1:0]   HOLD_LD  = SEC_W'(HOLD_SEC);
  localparam logic [SCORE_W-1:0] SMAX     = SCORE_W'(SCORE_MAX);

  round_state_e       state_q, state_d;
  logic [SEC_W-1:0]   sec_q, sec_d;
  logic               jump_q, jump_d;
  logic               done_q, done_d;
  logic               tick, clr_div, last_sec;
  logic [SCORE_W-1:0] score_q   [NUM_PLAYERS];
  logic [SCORE_W-1:0] score_inc [NUM_PLAYERS];
  logic [SCORE_W-1:0] last_q    [NUM_PLAYERS];

  // Restart the second count on every phase change so each phase gets whole seconds.
  assign clr_div  = (state_d != state_q);
  assign last_sec = (sec_q == SEC_W'(1));

  sec_tick #(.TICK_DIV(TICK_DIV)) u_sec_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_div),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sec_q   <= '0;
      jump_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      jump_q  <= jump_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    jump_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // start wins over a coincident abort; with no countdown go straight to play
        if (start) begin
          if (COUNTDOWN_SEC == 0) begin
            state_d = ST_GAME;
            sec_d   = ROUND_LD;
            jump_d  = 1'b1;
          end else begin
            state_d = ST_COUNT;
            sec_d   = CD_LD;
          end
        end
      end
      ST_COUNT: begin
        if (abort) begin
          state_d = ST_IDLE;
          sec_d   = '0;
        end else if (tick) begin
          if (last_sec) begin
            state_d = ST_GAME;
            sec_d   = ROUND_LD;
            jump_d  = 1'b1;
          end else begin
            sec_d = sec_q - SEC_W'(1);
          end
        end
      end
      ST_GAME: begin
        if (abort || (tick && last_sec)) begin
          state_d = ST_HOLD;
          sec_d   = HOLD_LD;
          done_d  = 1'b1;
        end else if (tick) begin
          sec_d = sec_q - SEC_W'(1);
        end
      end
      ST_HOLD: begin
        if (tick) begin
          if (last_sec) begin
            state_d = ST_IDLE;
            sec_d   = '0;
          end else begin
            sec_d = sec_q - SEC_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        sec_d   = '0;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      score_inc[i] = hit[i] ? sat_inc(score_q[i], SMAX) : score_q[i];
    end
  end

  // score_inc feeds last_score so a hit on the exit edge still counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        score_q[i] <= '0;
        last_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (jump_d) begin
          score_q[i] <= '0;
        end else if (state_q == ST_GAME) begin
          score_q[i] <= score_inc[i];
        end
        if (done_d) begin
          last_q[i] <= score_inc[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pack
    assign score[g*SCORE_W +: SCORE_W]      = score_q[g];
    assign last_score[g*SCORE_W +: SCORE_W] = last_q[g];
  end

`ifdef ROUND_CTRL_HISCORE_EN
  logic [SCORE_W-1:0] best_q, best_d;

  always_comb begin
    best_d = best_q;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (score_inc[i] > best_d) begin
        best_d = score_inc[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      best_q <= '0;
    end else if (done_d) begin
      best_q <= best_d;
    end
  end

  assign best_score = best_q;
`else
  assign best_score = '0;
`endif

  assign state      = state_q;
  assign sec_left   = sec_q;
  assign jump_start = jump_q;
  assign round_done = done_q;

endmodule

// File: tb/tb_round_ctrl.sv
// Directed bench for round_ctrl: phase timing, scoring, abort paths, reset,
// saturation and the zero-countdown build on a second instance.
module tb_round_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  hit = 2'b00;
  logic [1:0]  state;
  logic [5:0]  sec_left;
  logic [13:0] score, last_score;
  logic        jump_start, round_done;
  logic [6:0]  best_score;

  logic        s2_start = 1'b0;
  logic        s2_abort = 1'b0;
  logic [1:0]  s2_hit = 2'b00;
  logic [1:0]  s2_state;
  logic [5:0]  s2_sec_left;
  logic [13:0] s2_score, s2_last_score;
  logic        s2_jump_start, s2_round_done;
  logic [6:0]  s2_best_score;

  int n_checks = 0;
  int n_pass   = 0;
  int n;
  logic [13:0] exp_q[$];

  round_ctrl #(
    .TICK_DIV(10), .ROUND_SEC(5), .COUNTDOWN_SEC(3), .NUM_PLAYERS(2), .SCORE_MAX(99)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .hit(hit),
    .state(state), .sec_left(sec_left), .score(score), .last_score(last_score),
    .jump_start(jump_start), .round_done(round_done), .best_score(best_score)
  );

  round_ctrl #(
    .TICK_DIV(10), .ROUND_SEC(20), .COUNTDOWN_SEC(0), .NUM_PLAYERS(2), .SCORE_MAX(99)
  ) dut_sat (
    .clk(clk), .rst(rst), .start(s2_start), .abort(s2_abort), .hit(s2_hit),
    .state(s2_state), .sec_left(s2_sec_left), .score(s2_score), .last_score(s2_last_score),
    .jump_start(s2_jump_start), .round_done(s2_round_done), .best_score(s2_best_score)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [13:0] pair(input int p1, input int p0);
    return {7'(p1), 7'(p0)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic bit cond_met(input int sel);
    case (sel)
      0:       return jump_start;
      1:       return round_done;
      default: return state == 2'd0;
    endcase
  endfunction

  task automatic wait_cond(input int sel, input int limit, output int cnt);
    cnt = 0;
    while (!cond_met(sel) && cnt < limit) begin
      cyc();
      cnt++;
    end
    if (!cond_met(sel)) check($sformatf("timeout_%0d", sel), 32'd0, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
  endtask

  // scoreboard: every round_done must match the next queued last_score
  always @(negedge clk) begin
    if (!rst && round_done) begin
      if (exp_q.size() == 0) check("last_score_unexpected", 32'(last_score), 32'h3fff_ffff);
      else check("last_score_sb", 32'(last_score), 32'(exp_q.pop_front()));
    end
  end

  localparam logic [31:0] BEST_EXP =
`ifdef ROUND_CTRL_HISCORE_EN
    32'd7;
`else
    32'd0;
`endif

  initial begin
    repeat (3) cyc();
    rst = 1'b0;
    check("rst_state", 32'(state), 32'd0);
    check("rst_sec", 32'(sec_left), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_last", 32'(last_score), 32'd0);
    check("rst_best", 32'(best_score), 32'd0);
    check("rst_pulses", 32'({jump_start, round_done}), 32'd0);

    hit = 2'b11; cyc(); hit = 2'b00;
    check("idle_hit_ignored", 32'(score), 32'd0);
    pulse_abort();
    check("idle_abort_ignored", 32'(state), 32'd0);

    // round 1: timeout with {1,3}
    exp_q.push_back(pair(1, 3));
    pulse_start();
    check("r1_count_state", 32'(state), 32'd1);
    check("r1_count_sec", 32'(sec_left), 32'd3);
    wait_cond(0, 100, n);
    check("r1_count_len", 32'(n), 32'd30);
    check("r1_game_state", 32'(state), 32'd2);
    check("r1_game_sec", 32'(sec_left), 32'd5);
    check("r1_score_clear", 32'(score), 32'd0);
    hit = 2'b01; cyc();
    check("r1_jump_one_cycle", 32'(jump_start), 32'd0);
    cyc(); cyc();
    hit = 2'b10; cyc(); hit = 2'b00;
    check("r1_score", 32'(score), 32'(pair(1, 3)));
    check("r1_sec_mid", 32'(sec_left), 32'd5);
    wait_cond(1, 100, n);
    check("r1_game_len", 32'(n + 4), 32'd50);
    check("r1_hold_state", 32'(state), 32'd3);
    check("r1_hold_sec", 32'(sec_left), 32'd2);
    hit = 2'b11; start = 1'b1; cyc(); hit = 2'b00; start = 1'b0;
    check("r1_done_one_cycle", 32'(round_done), 32'd0);
    check("r1_hold_start_ignored", 32'(state), 32'd3);
    check("r1_hold_hit_ignored", 32'(score), 32'(pair(1, 3)));
    wait_cond(2, 100, n);
    check("r1_hold_len", 32'(n + 1), 32'd20);
    check("r1_idle_score_held", 32'(score), 32'(pair(1, 3)));
    check("r1_idle_sec", 32'(sec_left), 32'd0);

    // round 2: 7 hits on player 0, abort together with the 7th hit
    exp_q.push_back(pair(0, 7));
    pulse_start();
    wait_cond(0, 100, n);
    check("r2_count_len", 32'(n), 32'd30);
    hit = 2'b01;
    repeat (6) cyc();
    abort = 1'b1; cyc(); abort = 1'b0; hit = 2'b00;
    check("r2_abort_state", 32'(state), 32'd3);
    check("r2_abort_done", 32'(round_done), 32'd1);
    check("r2_score", 32'(score), 32'(pair(0, 7)));
    check("r2_best", 32'(best_score), BEST_EXP);
    wait_cond(2, 100, n);

    // round 3: 5 on player 1, best must stay at 7
    exp_q.push_back(pair(5, 0));
    pulse_start();
    wait_cond(0, 100, n);
    hit = 2'b10;
    repeat (4) cyc();
    abort = 1'b1; cyc(); abort = 1'b0; hit = 2'b00;
    check("r3_best", 32'(best_score), BEST_EXP);
    wait_cond(2, 100, n);

    // round 4: abort two cycles into GAME, hits on both edges
    exp_q.push_back(pair(2, 2));
    pulse_start();
    wait_cond(0, 100, n);
    hit = 2'b11; cyc();
    abort = 1'b1; cyc(); abort = 1'b0; hit = 2'b00;
    check("r4_abort_state", 32'(state), 32'd3);
    check("r4_abort_done", 32'(round_done), 32'd1);
    check("r4_score", 32'(score), 32'(pair(2, 2)));
    wait_cond(2, 100, n);

    // abort during countdown returns to IDLE, last_score untouched
    pulse_start();
    repeat (5) cyc();
    pulse_abort();
    check("cnt_abort_state", 32'(state), 32'd0);
    check("cnt_abort_sec", 32'(sec_left), 32'd0);
    check("cnt_abort_last", 32'(last_score), 32'(pair(2, 2)));
    check("cnt_abort_score", 32'(score), 32'(pair(2, 2)));
    check("cnt_abort_no_done", 32'(round_done), 32'd0);

    // start with abort in IDLE acts as start
    start = 1'b1; abort = 1'b1; cyc(); start = 1'b0; abort = 1'b0;
    check("start_abort_state", 32'(state), 32'd1);
    check("start_abort_sec", 32'(sec_left), 32'd3);

    // reset mid-GAME with score 4
    wait_cond(0, 100, n);
    hit = 2'b01; repeat (4) cyc(); hit = 2'b00;
    check("mid_score", 32'(score), 32'(pair(0, 4)));
    rst = 1'b1; cyc();
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_score", 32'(score), 32'd0);
    check("mid_rst_last", 32'(last_score), 32'd0);
    check("mid_rst_best", 32'(best_score), 32'd0);
    check("mid_rst_sec", 32'(sec_left), 32'd0);
    rst = 1'b0; cyc();

    // zero-countdown instance: direct entry and saturation
    s2_start = 1'b1; cyc(); s2_start = 1'b0;
    check("sat_direct_state", 32'(s2_state), 32'd2);
    check("sat_direct_sec", 32'(s2_sec_left), 32'd20);
    check("sat_direct_jump", 32'(s2_jump_start), 32'd1);
    s2_hit = 2'b10;
    repeat (120) cyc();
    s2_hit = 2'b00;
    check("sat_score", 32'(s2_score), 32'(pair(99, 0)));
    s2_abort = 1'b1; cyc(); s2_abort = 1'b0;
    check("sat_hold_state", 32'(s2_state), 32'd3);
    check("sat_done", 32'(s2_round_done), 32'd1);
    check("sat_last", 32'(s2_last_score), 32'(pair(99, 0)));

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
